extend: RTL and testbench

//  Parameterised zero/sign extender used in the datapath, e.g. for load-byte/halfword

---
 rtl/extend_pkg.sv | 11 +
 rtl/extend.sv | 59 +++++
 tb/tb_extend.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/extend_pkg.sv
// Shared datapath constants.
//   XLEN   : native datapath width, used as the default result width of extend
//   BYTE_W : width of a load-byte result
//   HALF_W : width of a load-halfword result
package extend_pkg;

  localparam int XLEN   = 32;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

endpackage : extend_pkg

// File: rtl/extend.sv
// Zero/sign extender for load results and immediates.
// Widens an INPUT_WIDTH operand to OUTPUT_WIDTH. The combinational result is the
// primary output. A registered copy is provided for pipelined callers.
//
// Parameters
//   INPUT_WIDTH  : operand width (default BYTE_W = 8)
//   OUTPUT_WIDTH : result width (default XLEN = 32), must be >= INPUT_WIDTH
// Ports
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; clears res_q only
//   data  : operand to extend
//   uext  : 1 = zero-extend, 0 = sign-extend
//   res   : extended result, combinational, unaffected by reset
//   res_q : res registered once (1-cycle latency), 0 after reset
// There is no handshake: res is valid whenever data/uext are, and res_q holds the
// res seen at the previous rising edge.
module extend
  import extend_pkg::*;
#(
  parameter int INPUT_WIDTH  = BYTE_W,
  parameter int OUTPUT_WIDTH = XLEN
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [INPUT_WIDTH-1:0]  data,
  input  logic                    uext,
  output logic [OUTPUT_WIDTH-1:0] res,
  output logic [OUTPUT_WIDTH-1:0] res_q
);

  // Parameter legality: an extender can never narrow its operand.
  generate
    if (INPUT_WIDTH < 1 || OUTPUT_WIDTH < INPUT_WIDTH) begin : g_bad_params
      $error("extend: illegal widths INPUT_WIDTH=%0d OUTPUT_WIDTH=%0d",
             INPUT_WIDTH, OUTPUT_WIDTH);
    end
  endgenerate

  // The low INPUT_WIDTH bits are always data; only the fill depends on uext,
  // so an unknown uext can only disturb the upper bits. When the widths match
  // there are no fill bits and uext has no effect.
  generate
    if (OUTPUT_WIDTH > INPUT_WIDTH) begin : g_ext
      localparam int FILL_W = OUTPUT_WIDTH - INPUT_WIDTH;
      assign res = {(uext ? {FILL_W{1'b0}} : {FILL_W{data[INPUT_WIDTH-1]}}), data};
    end else begin : g_pass
      assign res = data[OUTPUT_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
    end else begin
      res_q <= res;
    end
  end

endmodule : extend

// File: tb/tb_extend.sv
// Bench for extend: an 8->32 and a 16->32 instance driven side by side.
module tb_extend;
  import extend_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic reset  = 1'b1;

  always #5 if (clk_en) clk = ~clk;

  // ---------------- DUTs ----------------
  logic [BYTE_W-1:0] d8  = '0;
  logic [HALF_W-1:0] d16 = '0;
  logic              uext = 1'b0;
  logic [XLEN-1:0]   res8, res8_q, res16, res16_q;

  extend #(BYTE_W, XLEN) dut8 (
    .clk(clk), .reset(reset), .data(d8), .uext(uext), .res(res8), .res_q(res8_q)
  );

  extend #(HALF_W, XLEN) dut16 (
    .clk(clk), .reset(reset), .data(d16), .uext(uext), .res(res16), .res_q(res16_q)
  );

  // ---------------- scoreboard ----------------
  logic [XLEN-1:0] exp_q8[$];
  logic [XLEN-1:0] exp_q16[$];
  logic [XLEN-1:0] exp_q8r[$];
  logic [XLEN-1:0] exp_q16r[$];
  int n_checks = 0;
  int n_pass   = 0;
  event comb_ev;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the operand's value as an unsigned or two's-complement
  // integer, written out as an XLEN-bit word.
  function automatic logic [XLEN-1:0] model(input int unsigned d, input int w,
                                            input bit u);
    longint v;
    v = longint'(d);
    if (!u && d >= (32'd1 << (w - 1))) v = v - (longint'(1) << w);
    return v[XLEN-1:0];
  endfunction

  // Combinational monitor: one sample per driver event.
  initial begin
    forever begin
      @(comb_ev);
      if (exp_q8.size() == 0 || exp_q16.size() == 0) begin
        n_checks++;
        $display("FAIL comb_queue: empty when DUT result presented");
      end else begin
        check("res8",  res8,  exp_q8.pop_front());
        check("res16", res16, exp_q16.pop_front());
      end
    end
  end

  // Registered monitor: each rising edge consumes one expected res_q per DUT.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q8r.size() > 0)  check("res8_q",  res8_q,  exp_q8r.pop_front());
      if (exp_q16r.size() > 0) check("res16_q", res16_q, exp_q16r.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_comb(input logic [7:0] a, input logic [15:0] b, input bit u,
                            input logic [XLEN-1:0] e8, input logic [XLEN-1:0] e16);
    d8 = a; d16 = b; uext = u;
    exp_q8.push_back(e8);
    exp_q16.push_back(e16);
    #1;
    -> comb_ev;
    #1;
  endtask

  // Applied at a falling edge; expectation is for the following rising edge.
  task automatic drive_reg(input logic [7:0] a, input logic [15:0] b, input bit u,
                           input bit r);
    @(negedge clk);
    d8 = a; d16 = b; uext = u; reset = r;
    exp_q8r.push_back(r ? '0 : model(a, BYTE_W, u));
    exp_q16r.push_back(r ? '0 : model(b, HALF_W, u));
  endtask

  // ---------------- stimulus ----------------
  logic [7:0]      t_d8 [7] = '{8'h0F, 8'h0F, 8'h8F, 8'h8F, 8'h80, 8'h7F, 8'hFF};
  logic [15:0]     t_d16[7] = '{16'h800F, 16'h800F, 16'h7FFF, 16'h7FFF, 16'h8000,
                                16'hFFFF, 16'h0000};
  bit              t_u  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [XLEN-1:0] t_e8 [7] = '{32'h0000000F, 32'h0000000F, 32'h0000008F,
                                32'hFFFFFF8F, 32'hFFFFFF80, 32'h0000007F,
                                32'h000000FF};
  logic [XLEN-1:0] t_e16[7] = '{32'h0000800F, 32'hFFFF800F, 32'h00007FFF,
                                32'h00007FFF, 32'hFFFF8000, 32'hFFFFFFFF,
                                32'h00000000};

  initial begin
    logic [7:0]  a;
    logic [15:0] b;
    bit          u;

    // Combinational phase: clock stopped, reset wiggled to show it has no effect.
    #3;
    for (int i = 0; i < 7; i++) begin
      reset = i[0];
      drive_comb(t_d8[i], t_d16[i], t_u[i], t_e8[i], t_e16[i]);
    end
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 16'($urandom_range(0, 65535));
      u = 1'($urandom_range(0, 1));
      reset = 1'($urandom_range(0, 1));
      drive_comb(a, b, u, model(a, BYTE_W, u), model(b, HALF_W, u));
    end

    // Registered phase.
    clk_en = 1'b1;
    drive_reg(8'h00, 16'h0000, 1'b0, 1'b1);   // reset for one edge -> 0
    drive_reg(8'h80, 16'h8000, 1'b0, 1'b0);   // -> FFFFFF80 / FFFF8000
    drive_reg(8'h80, 16'h8000, 1'b0, 1'b1);   // reset mid-stream -> 0
    drive_reg(8'h7E, 16'hC001, 1'b1, 1'b0);   // first edge after reset captures res
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 16'($urandom_range(0, 65535));
      u = 1'($urandom_range(0, 1));
      drive_reg(a, b, u, $urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    @(negedge clk);

    n_checks++;
    if (exp_q8.size() == 0 && exp_q16.size() == 0 &&
        exp_q8r.size() == 0 && exp_q16r.size() == 0) n_pass++;
    else $display("FAIL drain: leftover expectations %0d/%0d/%0d/%0d required 0",
                  exp_q8.size(), exp_q16.size(), exp_q8r.size(), exp_q16r.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_extend
